// File: rtl/ram16_access_bridge.sv
// Host-side front end for the RAM16 4x32 byte-enable store.
// Translates byte/half/word requests on a valid/ready channel into
// word address + byte-lane mask, returns lane-extracted read data one
// cycle after acceptance, and zero-initialises the RAM after reset or
// on a clr request (RAM16 itself has no reset).
//
// Handshake: a request transfers on any rising CLK where
// req_valid && req_ready. The host keeps the request stable while
// req_valid && !req_ready. Every transfer produces exactly one
// rsp_valid pulse on the following cycle; there is no response
// backpressure.
module ram16_access_bridge #(
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        clr,
    output logic        init_done,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        ram_en,
    output logic [3:0]  ram_we,
    output logic [1:0]  ram_a,
    output logic [31:0] ram_di,
    input  logic [31:0] ram_do
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [1:0]  cnt_next;

    logic        misaligned;
    logic [3:0]  lane_mask;
    logic [31:0] size_mask;
    logic [4:0]  lane_shift;
    logic        accept;

    // Request decode: alignment check, byte-lane mask, data mask and shift.
    always_comb begin
        misaligned = 1'b0;
        lane_mask  = 4'h0;
        size_mask  = 32'h0;
        lane_shift = {req_addr[1:0], 3'b000};
        case (req_size)
            2'd0: begin
                lane_mask = 4'b0001 << req_addr[1:0];
                size_mask = 32'h0000_00FF;
            end
            2'd1: begin
                misaligned = req_addr[0];
                lane_mask  = 4'b0011 << {req_addr[1], 1'b0};
                size_mask  = 32'h0000_FFFF;
            end
            2'd2: begin
                misaligned = (req_addr[1:0] != 2'b00);
                lane_mask  = 4'hF;
                size_mask  = 32'hFFFF_FFFF;
            end
            default: begin
                misaligned = 1'b1;
                lane_mask  = 4'h0;
                size_mask  = 32'h0;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    // Next-state logic and combinational RAM port / ready drive.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 4'h0;
        ram_a      = 2'd0;
        ram_di     = 32'h0;
        if (!RST) begin
            case (state)
                ST_INIT: begin
                    ram_en   = 1'b1;
                    ram_we   = 4'hF;
                    ram_a    = cnt;
                    ram_di   = INIT_VALUE;
                    cnt_next = cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state_next = ST_IDLE;
                        cnt_next   = 2'd0;
                    end
                end
                ST_IDLE: begin
                    if (clr) begin
                        // clr wins over a simultaneous request.
                        state_next = ST_INIT;
                        cnt_next   = 2'd0;
                    end else begin
                        req_ready = 1'b1;
                        if (req_valid && !misaligned) begin
                            ram_en = 1'b1;
                            ram_a  = req_addr[3:2];
                            if (req_we) begin
                                ram_we = lane_mask;
                                ram_di = (req_wdata & size_mask) << lane_shift;
                            end
                        end
                    end
                end
                default: begin
                    state_next = ST_INIT;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // State register, sweep counter and sticky init_done flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            cnt       <= 2'd0;
            init_done <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == ST_INIT && cnt == 2'd3) begin
                init_done <= 1'b1;
            end
        end
    end

    // Response register: pulse after every accept, hold data otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_err <= misaligned;
                if (misaligned || req_we) begin
                    rsp_rdata <= 32'h0;
                end else begin
                    rsp_rdata <= (ram_do >> lane_shift) & size_mask;
                end
            end
        end
    end

endmodule

// File: tb/tb_ram16_access_bridge.sv
// Bench for ram16_access_bridge: behavioural RAM16 model, byte-array
// reference memory, directed scenarios followed by randomized traffic.
module tb_ram16_access_bridge;

  logic        CLK = 1'b0;
  logic        RST;
  logic        clr;
  logic        init_done;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [1:0]  ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  int checks = 0;
  int errors = 0;

  // RAM16 storage model and reference memory as plain bytes
  logic [31:0] ram_mem [4];
  logic [7:0]  ref_mem [16];

  always #5 CLK = ~CLK;

  ram16_access_bridge #(.INIT_VALUE(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .clr(clr), .init_done(init_done),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  assign ram_do = ram_en ? ram_mem[ram_a] : 32'h0;

  always @(posedge CLK) begin
    if (ram_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_we[i]) ram_mem[ram_a][8*i +: 8] <= ram_di[8*i +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 0;
    endcase
  endfunction

  // An access is legal when its size is defined and the address is a multiple of it
  function automatic bit is_bad(input logic [1:0] size, input logic [3:0] addr);
    int n;
    n = nbytes(size);
    if (n == 0) return 1'b1;
    return (int'(addr) % n) != 0;
  endfunction

  // Present one request, check port drive in the accept cycle and the response after it.
  task automatic issue(input bit we, input logic [1:0] size, input logic [3:0] addr, input logic [31:0] wdata);
    bit          err;
    int          n;
    int          lane;
    logic [3:0]  exp_we;
    logic [31:0] exp_di;
    logic [31:0] exp_rd;
    logic [1:0]  exp_a;
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    #2;
    err    = is_bad(size, addr);
    n      = nbytes(size);
    exp_we = 4'h0;
    exp_di = 32'h0;
    exp_rd = 32'h0;
    exp_a  = err ? 2'd0 : 2'(int'(addr) / 4);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        lane = (int'(addr) % 4) + i;
        if (we) begin
          exp_we[lane] = 1'b1;
          exp_di[8*lane +: 8] = wdata[8*i +: 8];
        end else begin
          exp_rd[8*i +: 8] = ref_mem[int'(addr) + i];
        end
      end
    end
    check("req_ready", req_ready, 1);
    check("acc_ram_en", ram_en, {31'h0, !err});
    check("acc_ram_we", ram_we, exp_we);
    check("acc_ram_a", ram_a, exp_a);
    check("acc_ram_di", ram_di, exp_di);
    @(posedge CLK);
    #1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, err);
    check("rsp_rdata", rsp_rdata, exp_rd);
    if (!err && we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
    end
  endtask

  task automatic idle_cycle();
    req_valid = 1'b0;
    #2;
    check("idle_ram_en", ram_en, 0);
    check("idle_ram_we", ram_we, 0);
    check("idle_ram_a", ram_a, 0);
    check("idle_ram_di", ram_di, 0);
    @(posedge CLK);
    #1;
    check("idle_rsp_valid", rsp_valid, 0);
  endtask

  // Observe ncyc sweep cycles starting at counter 0.
  task automatic sweep(input int ncyc, input bit check_done, input bit hold_clr);
    for (int k = 0; k < ncyc; k++) begin
      clr = hold_clr && (k < 3);
      #2;
      check("sweep_ram_en", ram_en, 1);
      check("sweep_ram_we", ram_we, 32'hF);
      check("sweep_ram_a", ram_a, k);
      check("sweep_ram_di", ram_di, 0);
      check("sweep_ready", req_ready, 0);
      if (check_done) check("sweep_init_done", init_done, 0);
      @(posedge CLK);
      #1;
      check("sweep_rsp_valid", rsp_valid, 0);
    end
    clr = 1'b0;
    if (ncyc == 4) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4; i++) ram_mem[i] = $urandom;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'hXX;
    RST = 1'b1; clr = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_addr = 4'd0; req_wdata = 32'h0;

    // Reset -> init
    @(posedge CLK); #1;
    check("rst_ready", req_ready, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    sweep(4, 1'b1, 1'b0);
    check("init_done", init_done, 1);
    check("ready_after_init", req_ready, 1);
    for (int w = 0; w < 4; w++) issue(1'b0, 2'd2, 4'(4*w), 32'h0);
    idle_cycle();

    // Byte lanes
    issue(1'b1, 2'd2, 4'h4, 32'h1122_3344);
    issue(1'b1, 2'd0, 4'h6, 32'h0000_00AA);
    issue(1'b0, 2'd1, 4'h6, 32'h0);
    check("lane_half", rsp_rdata, 32'h0000_11AA);
    issue(1'b0, 2'd0, 4'h5, 32'h0);
    check("lane_byte", rsp_rdata, 32'h0000_0033);

    // Errors
    issue(1'b1, 2'd1, 4'h3, 32'hFFFF_FFFF);
    issue(1'b0, 2'd2, 4'h2, 32'h0);
    issue(1'b1, 2'd3, 4'h0, 32'h5555_5555);
    issue(1'b0, 2'd2, 4'h4, 32'h0);
    check("err_unchanged", rsp_rdata, 32'h11AA_3344);

    // Back-to-back
    issue(1'b1, 2'd2, 4'hC, 32'hDEAD_BEEF);
    issue(1'b0, 2'd2, 4'hC, 32'h0);
    check("b2b_rdata", rsp_rdata, 32'hDEAD_BEEF);
    idle_cycle();

    // Randomized traffic
    for (int t = 0; t < 120; t++) begin
      if ($urandom_range(0, 5) == 0) idle_cycle();
      else issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), $urandom);
    end

    // clr collision, clr held during part of the sweep must not restart it
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 4'h4;
    clr = 1'b1;
    #2;
    check("clr_ready", req_ready, 0);
    check("clr_ram_en", ram_en, 0);
    @(posedge CLK); #1;
    check("clr_rsp_valid", rsp_valid, 0);
    sweep(4, 1'b0, 1'b1);
    issue(1'b0, 2'd2, 4'h4, 32'h0);
    check("clr_zero", rsp_rdata, 32'h0);
    issue(1'b0, 2'd2, 4'h0, 32'h0);
    issue(1'b0, 2'd2, 4'h8, 32'h0);
    issue(1'b0, 2'd2, 4'hC, 32'h0);
    issue(1'b1, 2'd2, 4'h8, $urandom);
    idle_cycle();

    // Reset mid-sweep
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    sweep(2, 1'b1, 1'b0);
    #2;
    check("mid_ram_a", ram_a, 2);
    RST = 1'b1;
    #1;
    check("mid_rst_ram_en", ram_en, 0);
    check("mid_rst_ready", req_ready, 0);
    @(posedge CLK); #1;
    RST = 1'b0;
    check("mid_init_done", init_done, 0);
    sweep(4, 1'b1, 1'b0);
    check("mid_done", init_done, 1);
    for (int w = 0; w < 4; w++) issue(1'b0, 2'd2, 4'(4*w), 32'h0);
    idle_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
